// File: rtl/seg_seq_monitor_pkg.sv
// Shared 7-segment constants and monitor state encoding.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg_seq_monitor_pkg;

  localparam logic [6:0] HEX_0 = 7'b1000000;
  localparam logic [6:0] HEX_1 = 7'b1111001;
  localparam logic [6:0] HEX_2 = 7'b0100100;
  localparam logic [6:0] HEX_3 = 7'b0110000;
  localparam logic [6:0] HEX_4 = 7'b0011001;
  localparam logic [6:0] HEX_5 = 7'b0010010;
  localparam logic [6:0] HEX_6 = 7'b0000010;
  localparam logic [6:0] HEX_7 = 7'b1111000;
  localparam logic [6:0] HEX_8 = 7'b0000000;
  localparam logic [6:0] HEX_9 = 7'b0011000;

  localparam logic [3:0] DIG_INV = 4'hF;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Active-low 7-segment pattern to BCD digit decoder.
// Ports: i_hex pattern in; o_digit 0-9 or DIG_INV; o_valid legal digit.
module seg7_decode
  import seg_seq_monitor_pkg::*;
(
  input  logic [6:0] i_hex,
  output logic [3:0] o_digit,
  output logic       o_valid
);

  logic [3:0] w_dig;

  always_comb begin
    w_dig = DIG_INV;
    unique case (i_hex)
      HEX_0:   w_dig = 4'd0;
      HEX_1:   w_dig = 4'd1;
      HEX_2:   w_dig = 4'd2;
      HEX_3:   w_dig = 4'd3;
      HEX_4:   w_dig = 4'd4;
      HEX_5:   w_dig = 4'd5;
      HEX_6:   w_dig = 4'd6;
      HEX_7:   w_dig = 4'd7;
      HEX_8:   w_dig = 4'd8;
      HEX_9:   w_dig = 4'd9;
      default: w_dig = DIG_INV;
    endcase
  end

  assign o_digit = w_dig;
  assign o_valid = (w_dig != DIG_INV);

endmodule

// File: rtl/seg_seq_monitor.sv
// Checks a 7-seg bus follows a mod-10 up/down count; reports lock/errors.
// Ports: clk, reset(n), sample_en, hex_in, dir -> digit, flags, counters.
module seg_seq_monitor
  import seg_seq_monitor_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [6:0]       hex_in,
  input  logic             dir,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] step_count,
  output logic [CNT_W-1:0] err_count
);

  state_t           r_state, w_state_nx;
  logic [3:0]       r_digit, w_digit_nx;
  logic             r_dv, w_dv_nx;
  logic             r_err, w_err_nx;
  logic [CNT_W-1:0] r_step, w_step_nx;
  logic [CNT_W-1:0] r_errc, w_errc_nx;

  logic [3:0]       w_dec;
  logic             w_ok;
  logic [3:0]       w_exp;
  logic             w_hit;
  logic             w_hold;
  logic [CNT_W-1:0] w_step_inc;
  logic [CNT_W-1:0] w_errc_inc;

  seg7_decode u_dec (
    .i_hex   (hex_in),
    .o_digit (w_dec),
    .o_valid (w_ok)
  );

  always_comb begin
    w_exp = 4'd0;
    if (dir)
      w_exp = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
    else
      w_exp = (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
  end

  assign w_hit  = w_ok && (w_dec == w_exp);
  assign w_hold = w_ok && ALLOW_HOLD && (w_dec == r_digit);

  assign w_step_inc = (&r_step) ? r_step : r_step + CNT_W'(1);
  assign w_errc_inc = (&r_errc) ? r_errc : r_errc + CNT_W'(1);

  always_comb begin
    w_state_nx = r_state;
    w_digit_nx = r_digit;
    w_dv_nx    = r_dv;
    w_err_nx   = 1'b0;
    w_step_nx  = r_step;
    w_errc_nx  = r_errc;
    if (sample_en) begin
      if (r_state == IDLE) begin
        w_dv_nx = w_ok;
        if (w_ok) begin
          w_digit_nx = w_dec;
          w_state_nx = LOCKED;
          w_step_nx  = '0;
        end
      end else begin
        unique case (1'b1)
          !w_ok: begin
            w_err_nx   = 1'b1;
            w_errc_nx  = w_errc_inc;
            w_dv_nx    = 1'b0;
            w_state_nx = IDLE;
          end
          w_hit: begin
            w_digit_nx = w_dec;
            w_dv_nx    = 1'b1;
            w_step_nx  = w_step_inc;
          end
          w_hold: begin
            w_dv_nx = 1'b1;
          end
          default: begin
            // Re-baseline on the observed digit and keep tracking.
            w_err_nx   = 1'b1;
            w_errc_nx  = w_errc_inc;
            w_digit_nx = w_dec;
            w_dv_nx    = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_digit <= 4'd0;
      r_dv    <= 1'b0;
      r_err   <= 1'b0;
      r_step  <= '0;
      r_errc  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_digit <= w_digit_nx;
      r_dv    <= w_dv_nx;
      r_err   <= w_err_nx;
      r_step  <= w_step_nx;
      r_errc  <= w_errc_nx;
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_dv;
  assign locked      = (r_state == LOCKED);
  assign err         = r_err;
  assign step_count  = r_step;
  assign err_count   = r_errc;

endmodule

// File: tb/tb_seg_seq_monitor.sv
// Scoreboard bench for seg_seq_monitor, hold and no-hold instances.
// Reference model results queued on drive, compared after the edge.
module tb_seg_seq_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_en = 1'b0;
  logic [6:0] hex_in = 7'h7F;
  logic       dir = 1'b1;

  logic [3:0] digit, digit_b;
  logic       dv, dv_b, lk, lk_b, er, er_b;
  logic [7:0] sc, sc_b, ec, ec_b;

  always #5 clk = ~clk;

  seg_seq_monitor #(.CNT_W(8), .ALLOW_HOLD(1'b1)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en),
    .hex_in(hex_in), .dir(dir), .digit(digit),
    .digit_valid(dv), .locked(lk), .err(er),
    .step_count(sc), .err_count(ec)
  );

  seg_seq_monitor #(.CNT_W(8), .ALLOW_HOLD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .sample_en(sample_en),
    .hex_in(hex_in), .dir(dir), .digit(digit_b),
    .digit_valid(dv_b), .locked(lk_b), .err(er_b),
    .step_count(sc_b), .err_count(ec_b)
  );

  localparam logic [6:0] P [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef struct {
    int locked; int digit; int dv; int err; int step; int errc;
  } mdl_t;
  typedef struct { mdl_t a; mdl_t b; } pair_t;

  mdl_t  ma, mb;
  pair_t q[$];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dec(logic [6:0] h);
    for (int i = 0; i < 10; i++)
      if (P[i] == h) return i;
    return -1;
  endfunction

  function automatic int sat(int x);
    return (x < 255) ? x + 1 : 255;
  endfunction

  function automatic mdl_t mstep(mdl_t m, logic [6:0] h, logic d, bit hold);
    mdl_t n;
    int   v;
    int   ex;
    n = m;
    n.err = 0;
    v = dec(h);
    if (m.locked == 0) begin
      n.dv = (v >= 0) ? 1 : 0;
      if (v >= 0) begin
        n.digit = v; n.locked = 1; n.step = 0;
      end
    end else begin
      if (d) ex = (m.digit == 9) ? 0 : m.digit + 1;
      else   ex = (m.digit == 0) ? 9 : m.digit - 1;
      if (v < 0) begin
        n.err = 1; n.errc = sat(m.errc); n.dv = 0; n.locked = 0;
      end else if (v == ex) begin
        n.digit = v; n.dv = 1; n.step = sat(m.step);
      end else if (v == m.digit && hold) begin
        n.dv = 1;
      end else begin
        n.err = 1; n.errc = sat(m.errc); n.digit = v; n.dv = 1;
      end
    end
    return n;
  endfunction

  task automatic cmp(string tag, mdl_t a, mdl_t b);
    chk({tag, ".lk"}, lk, a.locked);
    chk({tag, ".dg"}, digit, a.digit);
    chk({tag, ".dv"}, dv, a.dv);
    chk({tag, ".er"}, er, a.err);
    chk({tag, ".sc"}, sc, a.step);
    chk({tag, ".ec"}, ec, a.errc);
    chk({tag, ".lk0"}, lk_b, b.locked);
    chk({tag, ".dg0"}, digit_b, b.digit);
    chk({tag, ".dv0"}, dv_b, b.dv);
    chk({tag, ".er0"}, er_b, b.err);
    chk({tag, ".sc0"}, sc_b, b.step);
    chk({tag, ".ec0"}, ec_b, b.errc);
  endtask

  task automatic pop_cmp(string tag);
    pair_t e;
    if (q.size() == 0) begin
      chk({tag, ".qempty"}, 1, 0);
    end else begin
      e = q.pop_front();
      cmp(tag, e.a, e.b);
    end
  endtask

  task automatic smp(string tag, logic [6:0] h, logic d);
    hex_in = h;
    dir = d;
    sample_en = 1'b1;
    ma = mstep(ma, h, d, 1'b1);
    mb = mstep(mb, h, d, 1'b0);
    q.push_back('{ma, mb});
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    pop_cmp(tag);
  endtask

  task automatic idle(string tag);
    sample_en = 1'b0;
    hex_in = P[3];
    ma.err = 0;
    mb.err = 0;
    q.push_back('{ma, mb});
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  task automatic rst(string tag);
    reset = 1'b0;
    sample_en = 1'b0;
    ma = '{0, 0, 0, 0, 0, 0};
    mb = ma;
    #1;
    cmp({tag, ".async"}, ma, mb);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cmp(tag, ma, mb);
  endtask

  initial begin
    rst("rst0");
    foreach (P[i]) if (i <= 3) smp("up", P[i], 1'b1);
    chk("t1.step", sc, 3);
    chk("t1.digit", digit, 3);
    idle("idle");

    rst("rst1");
    smp("w8", P[8], 1'b1);
    smp("w9", P[9], 1'b1);
    smp("w0", P[0], 1'b1);
    smp("w1", P[1], 1'b1);
    smp("d1", P[1], 1'b0);
    smp("d0", P[0], 1'b0);
    smp("d9", P[9], 1'b0);
    smp("d8", P[8], 1'b0);
    chk("t2.step", sc, 6);
    chk("t2.ec", ec, 0);

    rst("rst2");
    smp("j4", P[4], 1'b1);
    smp("j6", P[6], 1'b1);
    chk("t3.err", er, 1);
    chk("t3.ec", ec, 1);
    smp("j7", P[7], 1'b1);
    chk("t3.noerr", er, 0);

    rst("rst3");
    smp("b5", P[5], 1'b1);
    smp("blank", BLANK, 1'b1);
    chk("t4.digit", digit, 5);
    chk("t4.lk", lk, 0);
    smp("b2", P[2], 1'b1);
    chk("t4.step", sc, 0);

    rst("rst4");
    smp("h3a", P[3], 1'b1);
    smp("h3b", P[3], 1'b1);
    smp("h4", P[4], 1'b1);
    chk("t5.step", sc, 1);
    chk("t5.ec0", ec_b, 1);

    rst("rst5");
    smp("a0", P[0], 1'b1);
    smp("a5", P[5], 1'b1);
    smp("a7", P[7], 1'b1);
    chk("t6.ec", ec, 2);
    #2;
    rst("midrst");

    smp("s0", P[0], 1'b1);
    for (int i = 0; i < 256; i++)
      smp("sat", (i % 2 == 0) ? P[5] : P[0], 1'b1);
    chk("t6.sat", ec, 255);
    chk("t6.sat0", ec_b, 255);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg_seq_monitor.md
Name: seg_seq_monitor

Overview:
- Receive-side counterpart of the 7-segment counter display path: observes an active-low 7-segment bus (gfedcba) and decodes each pattern back to a BCD digit.
- Checks that successive digits follow a mod-10 up/down count sequence selected by a direction input.
- Reports lock, per-sample errors and saturating statistics.
- Sits beside the counter top in both simulation and on-board self-check, driven from the same clock as the counter.

Parameters:
- CNT_W, 8, width of the step and error counters (saturating).
- ALLOW_HOLD, 1: if 1, a repeated digit is a legal hold; if 0, a repeated digit is a sequence error.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- sample_en  input  1  qualifies hex_in for this cycle.
- hex_in  input  7  active-low segments {g,f,e,d,c,b,a}.
- dir  input  1  1 = expect count up, 0 = expect count down; sampled with sample_en.
- digit  output  4  last decoded digit, 0-9.
- digit_valid  output  1  last sample decoded to a legal digit.
- locked  output  1  monitor is tracking a sequence.
- err  output  1  one-cycle pulse on a sequence or decode error.
- step_count  output  CNT_W  legal advancing steps seen since lock.
- err_count  output  CNT_W  errors since reset.

Behaviour:
Reset:
- reset low forces immediately: IDLE; digit=0; digit_valid=0; locked=0; err=0; both counters 0.
- Reset mid-sequence discards all history.

Decode:
- Combinational lookup of the ten legal patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000.
- Any other pattern is invalid.

Registering and latency:
- All outputs are registered and update on the clk edge where sample_en=1, visible the following cycle.
- With sample_en=0, all state holds and err=0.

Expected value:
- exp = dir ? (prev==9 ? 0 : prev+1) : (prev==0 ? 9 : prev-1).
- dir is the value present on the sample edge, so a direction change takes effect on the first sample after it.

States:
- IDLE
  - Valid sample: digit<=dec, digit_valid=1, go to LOCKED, step_count<=0.
  - Invalid sample: digit_valid=0, stay in IDLE, no err. Blank or garbage before lock is ignored.
- LOCKED
  - Valid and dec==exp: digit<=dec, step_count+1 (saturate at all-ones).
  - Valid and dec==prev and ALLOW_HOLD=1: no step, no error.
  - Valid and any other value (including a hold when ALLOW_HOLD=0): err=1, err_count+1 (saturate), digit<=dec. Re-baselines on the observed digit and stays in LOCKED; step_count unchanged.
  - Invalid sample: err=1, err_count+1, digit_valid=0, go to IDLE, locked=0. digit holds its last valid value.

Other rules:
- locked=1 exactly while in LOCKED.
- err never stays high for two cycles unless two consecutive erroneous samples occur.
- Wrap boundaries: 9→0 (up) and 0→9 (down) are legal steps, not errors.
- Counters saturate and never wrap.

Decomposition:
- Shared package holds:
  - the ten HEX pattern constants (shared with the display encoder);
  - state encoding localparams IDLE and LOCKED;
  - the invalid-digit code 4'hF.
- One natural sub-module: seg7_decode (7-bit pattern → 4-bit digit + valid), purely combinational, reusable by other checkers.
- FSM, expected-value logic and counters stay in seg_seq_monitor.

Test Plan:
- Reset low then high, drive 0,1,2,3 with dir=1, sample_en=1 each cycle → locked=1 after the first sample, err never set, step_count=3, digit=3.
- Drive 8,9,0,1 with dir=1, then 1,0,9,8 with dir=0 → no err, wrap counted both ways, step_count=6 after the second sequence's last sample.
- Locked at 4, dir=1, drive 6 → err pulses once, err_count=1, digit=6; next drive 7 → legal step, no err.
- Locked at 5, drive 7'b1111111 (blank) → err=1, locked=0, digit_valid=0, digit stays 5; then drive 2 → re-lock with no err and step_count=0.
- ALLOW_HOLD=1: drive 3,3,4 → no err, step_count=1. ALLOW_HOLD=0: same stimulus → one err on the second 3.
- Assert reset low asynchronously mid-cycle while locked with err_count=2 → all outputs 0 and IDLE without waiting for a clk edge; 256 forced errors with CNT_W=8 → err_count holds at 255.
